// File: rtl/verilab_chip_apb_regs_if.sv
// APB3 bus bundle between the bench agent (master) and verilab_chip_apb_regs (slave).
interface verilab_chip_apb_regs_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/verilab_chip_apb_regs.sv
// APB3 control/status register block: ID, CTRL, LOAD, COUNT, STATUS, SCRATCH and a
// down-counting timer with a level interrupt.
// Optional build macro VERILAB_CHIP_APB_PSLVERR_EN: when defined, unmapped accesses and
// writes to ID/COUNT answer with pslverr; otherwise pslverr is tied low.
module verilab_chip_apb_regs #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMER_W = 16,
    parameter logic [31:0] CHIP_ID = 32'h5645_4C31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    verilab_chip_apb_regs_if.slave apb,
    output logic                  irq
);

    localparam logic [5:0] AddrId      = 6'h00;
    localparam logic [5:0] AddrCtrl    = 6'h01;
    localparam logic [5:0] AddrLoad    = 6'h02;
    localparam logic [5:0] AddrCount   = 6'h03;
    localparam logic [5:0] AddrStatus  = 6'h04;
    localparam logic [5:0] AddrScratch = 6'h05;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;

    logic [2:0]          ctrl_q, ctrl_d;       // [0] timer_en, [1] irq_en, [2] one_shot
    logic [TIMER_W-1:0]  load_q, load_d;
    logic [TIMER_W-1:0]  count_q, count_d;
    logic                expired_q, expired_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;

    logic [5:0]          word_addr;
    logic [DATA_W-1:0]   rdata;
    logic                wr_en;
    logic                unused_paddr;

    assign word_addr    = apb.paddr[7:2];
    assign unused_paddr = ^apb.paddr;
    // pready_q is high only in ACCESS, so this is the single commit point of a write.
    assign wr_en        = apb.psel & apb.penable & pready_q & apb.pwrite;

    // Read-data mux over the current register contents.
    always_comb begin
        rdata = '0;
        case (word_addr)
            AddrId:      rdata = DATA_W'(CHIP_ID);
            AddrCtrl:    rdata[2:0] = ctrl_q;
            AddrLoad:    rdata[TIMER_W-1:0] = load_q;
            AddrCount:   rdata[TIMER_W-1:0] = count_q;
            AddrStatus:  rdata[0] = expired_q;
            AddrScratch: rdata = scratch_q;
            default:     rdata = '0;
        endcase
    end

    // Bus FSM next state: data and pready are prepared in SETUP so ACCESS is served from flops.
    always_comb begin
        state_d  = state_q;
        pready_d = 1'b0;
        prdata_d = prdata_q;
        unique case (state_q)
            StIdle: begin
                // penable without a prior setup phase is ignored here.
                if (apb.psel && !apb.penable) state_d = StSetup;
            end
            StSetup: begin
                state_d  = StAccess;
                pready_d = 1'b1;
                prdata_d = apb.pwrite ? '0 : rdata;
            end
            StAccess: begin
                state_d = (apb.psel && !apb.penable) ? StSetup : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef VERILAB_CHIP_APB_PSLVERR_EN
    logic err;
    logic pslverr_q, pslverr_d;

    // Error decode: unmapped addresses, or writes to read-only registers.
    always_comb begin
        err = 1'b0;
        case (word_addr)
            AddrId, AddrCount:                         err = apb.pwrite;
            AddrCtrl, AddrLoad, AddrStatus, AddrScratch: err = 1'b0;
            default:                                   err = 1'b1;
        endcase
        pslverr_d = (state_q == StSetup) & err;
    end

    // Error flag is registered alongside pready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pslverr_q <= 1'b0;
        else        pslverr_q <= pslverr_d;
    end

    assign apb.pslverr = pslverr_q;
`else
    assign apb.pslverr = 1'b0;
`endif

    // Bus FSM state and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prdata_q <= prdata_d;
            pready_q <= pready_d;
        end
    end

    assign apb.prdata = prdata_q;
    assign apb.pready = pready_q;

    // Register writes and timer. Order matters: W1C before expiry (set wins), timer
    // self-clear before the CTRL write (bus write wins).
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        scratch_d = scratch_q;

        if (wr_en && word_addr == AddrStatus && apb.pwdata[0]) expired_d = 1'b0;

        if (ctrl_q[0]) begin
            if (count_q == '0) begin
                expired_d = 1'b1;
                if (ctrl_q[2]) ctrl_d[0] = 1'b0;
                else           count_d   = load_q;
            end else begin
                count_d = count_q - TIMER_W'(1);
            end
        end

        if (wr_en) begin
            case (word_addr)
                AddrCtrl: begin
                    ctrl_d = apb.pwdata[2:0];
                    if (apb.pwdata[0] && !ctrl_q[0]) count_d = load_q;
                end
                AddrLoad:    load_d    = apb.pwdata[TIMER_W-1:0];
                AddrScratch: scratch_d = apb.pwdata;
                default: ;
            endcase
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            scratch_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            scratch_q <= scratch_d;
        end
    end

    // Both operands are flops, so irq has no combinational path from the bus.
    assign irq = expired_q & ctrl_q[1];

endmodule

// File: tb/tb_verilab_chip_apb_regs.sv
// Directed bench for verilab_chip_apb_regs with a queue scoreboard for APB responses.
module tb_verilab_chip_apb_regs;

`ifdef VERILAB_CHIP_APB_PSLVERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    localparam logic [31:0] ID = 32'h5645_4C31;

    logic clk;
    logic rst_n;
    logic irq;
    int   n_assert = 0;
    int   n_fail   = 0;

    typedef struct {
        string       tag;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } sb_item_t;

    sb_item_t exp_q[$];

    verilab_chip_apb_regs_if #(.ADDR_W(8), .DATA_W(32)) apb ();

    verilab_chip_apb_regs #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMER_W(16),
        .CHIP_ID(32'h5645_4C31)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .apb  (apb),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; call and return at a negedge.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input logic exp_err, input string tag);
        sb_item_t item;
        logic     got;
        item.tag   = tag;
        item.wr    = wr;
        item.rdata = exp_rd;
        item.err   = exp_err;
        exp_q.push_back(item);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        @(negedge clk);
        apb.penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (apb.pready) got = 1'b1;
        end
        item = exp_q.pop_front();
        check({item.tag, "_pready"}, {31'b0, got}, 32'd1);
        if (got) begin
            if (!item.wr) check({item.tag, "_prdata"}, apb.prdata, item.rdata);
            check({item.tag, "_pslverr"}, {31'b0, apb.pslverr}, {31'b0, item.err});
            @(negedge clk);
            check({item.tag, "_pready_1cyc"}, {31'b0, apb.pready}, 32'd0);
        end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] addr, input logic [31:0] d, input logic err,
                          input string tag);
        apb_xfer(1'b1, addr, d, 32'h0, err, tag);
    endtask

    task automatic apb_rd(input logic [7:0] addr, input logic [31:0] exp, input logic err,
                          input string tag);
        apb_xfer(1'b0, addr, 32'h0, exp, err, tag);
    endtask

    task automatic check_irq(input logic exp, input string tag);
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        rst_n       = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_prdata", apb.prdata, 32'h0);
        check("rst_pready", {31'b0, apb.pready}, 32'h0);
        check("rst_pslverr", {31'b0, apb.pslverr}, 32'h0);
        check_irq(1'b0, "rst_irq");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        apb_rd(8'h00, ID, 1'b0, "rd_id");
        apb_rd(8'h04, 32'h0, 1'b0, "rd_ctrl_rst");
        apb_rd(8'h08, 32'h0, 1'b0, "rd_load_rst");
        apb_rd(8'h0C, 32'h0, 1'b0, "rd_count_rst");
        apb_rd(8'h10, 32'h0, 1'b0, "rd_status_rst");
        apb_rd(8'h14, 32'h0, 1'b0, "rd_scratch_rst");

        // Scratch, unmapped, RO drop, LOAD width
        apb_wr(8'h14, 32'hDEAD_BEEF, 1'b0, "wr_scratch");
        apb_rd(8'h14, 32'hDEAD_BEEF, 1'b0, "rd_scratch");
        apb_rd(8'h17, 32'hDEAD_BEEF, 1'b0, "rd_scratch_unaligned");
        apb_rd(8'h18, 32'h0, ERR, "rd_unmapped");
        apb_wr(8'h00, 32'h0, ERR, "wr_id");
        apb_rd(8'h00, ID, 1'b0, "rd_id_after_wr");
        apb_wr(8'h08, 32'hFFFF_FFFF, 1'b0, "wr_load_full");
        apb_rd(8'h08, 32'h0000_FFFF, 1'b0, "rd_load_full");

        // Malformed access: penable without setup must not respond or write
        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        apb.pwrite  = 1'b1;
        apb.paddr   = 8'h14;
        apb.pwdata  = 32'h0000_0BAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("malformed_pready", {31'b0, apb.pready}, 32'h0);
        end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        @(negedge clk);
        apb_rd(8'h14, 32'hDEAD_BEEF, 1'b0, "rd_scratch_malformed");

        // Periodic timer, LOAD=3: expiry 4 cycles after the enable edge
        apb_wr(8'h08, 32'h3, 1'b0, "wr_load3");
        apb_wr(8'h04, 32'h3, 1'b0, "wr_ctrl3");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_irq(1'b0, $sformatf("per_irq_low_c%0d", i));
        end
        @(negedge clk);
        check_irq(1'b1, "per_irq_c4");
        apb_wr(8'h10, 32'h1, 1'b0, "w1c_status");
        check_irq(1'b0, "per_irq_cleared_c7");
        @(negedge clk);
        check_irq(1'b1, "per_irq_c8");
        @(negedge clk);
        // This W1C commits on the same edge as the expiry at cycle 12
        apb_wr(8'h10, 32'h1, 1'b0, "w1c_on_expiry");
        check_irq(1'b1, "w1c_collide_irq");
        apb_rd(8'h10, 32'h1, 1'b0, "rd_status_collide");
        apb_wr(8'h04, 32'h0, 1'b0, "wr_ctrl_off");
        apb_wr(8'h10, 32'h1, 1'b0, "w1c_status2");
        apb_rd(8'h10, 32'h0, 1'b0, "rd_status_cleared");

        // One-shot timer, LOAD=2
        apb_wr(8'h08, 32'h2, 1'b0, "wr_load2");
        apb_wr(8'h04, 32'h7, 1'b0, "wr_ctrl7");
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check_irq(1'b0, $sformatf("os_irq_low_c%0d", i));
        end
        @(negedge clk);
        check_irq(1'b1, "os_irq_c3");
        apb_rd(8'h04, 32'h6, 1'b0, "rd_ctrl_os");
        apb_rd(8'h0C, 32'h0, 1'b0, "rd_count_os");
        apb_wr(8'h10, 32'h1, 1'b0, "w1c_os");
        check_irq(1'b0, "os_irq_cleared");
        repeat (8) @(negedge clk);
        check_irq(1'b0, "os_no_reexpiry");
        apb_rd(8'h10, 32'h0, 1'b0, "rd_status_os");

        // Write to read-only COUNT
        apb_wr(8'h0C, 32'h5, ERR, "wr_count");
        apb_rd(8'h0C, 32'h0, 1'b0, "rd_count_after_wr");

        // Reset asserted during ACCESS of a scratch write
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 8'h14;
        apb.pwdata  = 32'h1234_5678;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        check("rst_mid_pready_before", {31'b0, apb.pready}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_pready_async", {31'b0, apb.pready}, 32'h0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apb_rd(8'h14, 32'h0, 1'b0, "rd_scratch_after_rst");
        apb_rd(8'h04, 32'h0, 1'b0, "rd_ctrl_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
